// File: rtl/sprite_motion_ctrl.sv
// Player-sprite motion controller: rate-limited stepping, facing/walk animation and per-pixel sprite hit/ROM address.
// Optional: define SPRITE_WRAP_EN to wrap at play-area bounds instead of clamping.
module sprite_motion_ctrl #(
   parameter int COORD_W    = 10,
   parameter int SPR_W      = 16,
   parameter int SPR_H      = 16,
   parameter int MIN_X      = 0,
   parameter int MAX_X      = 640,
   parameter int MIN_Y      = 16,
   parameter int MAX_Y      = 480,
   parameter int START_X    = 0,
   parameter int START_Y    = 16,
   parameter int STEP_DIV   = 4,
   parameter int FRAME_DIV  = 8,
   parameter int NUM_FRAMES = 4
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          L,
   input  logic                          R,
   input  logic                          U,
   input  logic                          D,
   input  logic [3:0]                    blocked,
   input  logic                          game_over,
   input  logic [COORD_W-1:0]            v_x,
   input  logic [COORD_W-1:0]            v_y,
   output logic [COORD_W-1:0]            b_x,
   output logic [COORD_W-1:0]            b_y,
   output logic [1:0]                    facing,
   output logic                          moving,
   output logic [$clog2(NUM_FRAMES)-1:0] anim_frame,
   output logic                          sprite_on,
   output logic [$clog2(SPR_H)-1:0]      rom_row,
   output logic [$clog2(SPR_W)-1:0]      rom_col
);
   localparam int XW  = COORD_W + 1;
   localparam int FW  = $clog2(NUM_FRAMES);
   localparam int SCW = $clog2(STEP_DIV + 1);
   localparam int FCW = $clog2(FRAME_DIV + 1);

   localparam logic [XW-1:0]  LO_X       = XW'(MIN_X);
   localparam logic [XW-1:0]  HI_X       = XW'(MAX_X - SPR_W);
   localparam logic [XW-1:0]  LO_Y       = XW'(MIN_Y);
   localparam logic [XW-1:0]  HI_Y       = XW'(MAX_Y - SPR_H);
   localparam logic [XW-1:0]  SPR_W_M1   = XW'(SPR_W - 1);
   localparam logic [XW-1:0]  SPR_H_M1   = XW'(SPR_H - 1);
   localparam logic [SCW-1:0] STEP_LAST  = SCW'(STEP_DIV - 1);
   localparam logic [FCW-1:0] FRAME_LAST = FCW'(FRAME_DIV - 1);
   localparam logic [FW-1:0]  ANIM_LAST  = FW'(NUM_FRAMES - 1);

   typedef enum logic [2:0] {IDLE, MV_L, MV_R, MV_U, MV_D} state_t;

   state_t               r_state;
   logic [COORD_W-1:0]   r_bx, r_by;
   logic [1:0]           r_facing;
   logic                 r_moving;
   logic [FW-1:0]        r_anim;
   logic [SCW-1:0]       r_step_cnt;
   logic [FCW-1:0]       r_frame_cnt;

   logic w_only_l, w_only_r, w_only_u, w_only_d, w_one;
   logic w_hold, w_step_edge, w_step_ok;
   logic [XW-1:0] w_bx_ext, w_by_ext, w_vx_ext, w_vy_ext, w_nx, w_ny;

   assign w_only_l    = L & ~R & ~U & ~D;
   assign w_only_r    = ~L & R & ~U & ~D;
   assign w_only_u    = ~L & ~R & U & ~D;
   assign w_only_d    = ~L & ~R & ~U & D;
   assign w_one       = w_only_l | w_only_r | w_only_u | w_only_d;
   assign w_step_edge = (r_step_cnt == STEP_LAST);
   assign w_bx_ext    = {1'b0, r_bx};
   assign w_by_ext    = {1'b0, r_by};
   assign w_vx_ext    = {1'b0, v_x};
   assign w_vy_ext    = {1'b0, v_y};

   // Staying in a MV state requires its button alone and no game_over; any exit edge takes no step.
   always_comb begin
      w_hold = 1'b0;
      case (r_state)
         MV_L:    w_hold = w_only_l & ~game_over;
         MV_R:    w_hold = w_only_r & ~game_over;
         MV_U:    w_hold = w_only_u & ~game_over;
         MV_D:    w_hold = w_only_d & ~game_over;
         default: w_hold = 1'b0;
      endcase
   end

   always_comb begin
      w_nx      = w_bx_ext;
      w_ny      = w_by_ext;
      w_step_ok = 1'b0;
      case (r_state)
         MV_L: if (!blocked[3]) begin
            if (w_bx_ext > LO_X) begin
               w_nx = w_bx_ext - XW'(1); w_step_ok = 1'b1;
            end else begin
`ifdef SPRITE_WRAP_EN
               w_nx = HI_X; w_step_ok = 1'b1;
`endif
            end
         end
         MV_R: if (!blocked[2]) begin
            if (w_bx_ext < HI_X) begin
               w_nx = w_bx_ext + XW'(1); w_step_ok = 1'b1;
            end else begin
`ifdef SPRITE_WRAP_EN
               w_nx = LO_X; w_step_ok = 1'b1;
`endif
            end
         end
         MV_U: if (!blocked[1]) begin
            if (w_by_ext > LO_Y) begin
               w_ny = w_by_ext - XW'(1); w_step_ok = 1'b1;
            end else begin
`ifdef SPRITE_WRAP_EN
               w_ny = HI_Y; w_step_ok = 1'b1;
`endif
            end
         end
         MV_D: if (!blocked[0]) begin
            if (w_by_ext < HI_Y) begin
               w_ny = w_by_ext + XW'(1); w_step_ok = 1'b1;
            end else begin
`ifdef SPRITE_WRAP_EN
               w_ny = LO_Y; w_step_ok = 1'b1;
`endif
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state     <= IDLE;
         r_bx        <= COORD_W'(START_X);
         r_by        <= COORD_W'(START_Y);
         r_facing    <= 2'd3;
         r_moving    <= 1'b0;
         r_anim      <= '0;
         r_step_cnt  <= '0;
         r_frame_cnt <= '0;
      end else if (r_state == IDLE) begin
         r_step_cnt  <= '0;
         r_frame_cnt <= '0;
         r_anim      <= '0;
         if (w_one && !game_over) begin
            r_moving <= 1'b1;
            if (w_only_l)      begin r_state <= MV_L; r_facing <= 2'd0; end
            else if (w_only_r) begin r_state <= MV_R; r_facing <= 2'd1; end
            else if (w_only_u) begin r_state <= MV_U; r_facing <= 2'd2; end
            else               begin r_state <= MV_D; r_facing <= 2'd3; end
         end
      end else if (!w_hold) begin
         r_state     <= IDLE;
         r_moving    <= 1'b0;
         r_step_cnt  <= '0;
         r_frame_cnt <= '0;
         r_anim      <= '0;
      end else if (w_step_edge) begin
         r_step_cnt <= '0;
         if (w_step_ok) begin
            r_bx <= COORD_W'(w_nx);
            r_by <= COORD_W'(w_ny);
            if (r_frame_cnt == FRAME_LAST) begin
               r_frame_cnt <= '0;
               r_anim      <= (r_anim == ANIM_LAST) ? '0 : r_anim + FW'(1);
            end else begin
               r_frame_cnt <= r_frame_cnt + FCW'(1);
            end
         end
      end else begin
         r_step_cnt <= r_step_cnt + SCW'(1);
      end
   end

   assign b_x        = r_bx;
   assign b_y        = r_by;
   assign facing     = r_facing;
   assign moving     = r_moving;
   assign anim_frame = r_anim;

   assign sprite_on = (w_vx_ext >= w_bx_ext) && (w_vx_ext <= w_bx_ext + SPR_W_M1) &&
                      (w_vy_ext >= w_by_ext) && (w_vy_ext <= w_by_ext + SPR_H_M1);
   assign rom_row   = $clog2(SPR_H)'(v_y - r_by);
   assign rom_col   = $clog2(SPR_W)'(v_x - r_bx);
endmodule
